// File: rtl/bytestriping_n_pkg.sv
`default_nettype none
// ============================================================
// bs_pkg : shared defaults, fill-state encoding, index width
// Rev 1.0
// ============================================================
package bs_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Lane-index width; never below 1 so a 2-lane build still has a pointer bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bytestriping_n_if.sv
`default_nettype none
// ============================================================
// bytestriping_n_if : word-in / stripe-out bus of the striper
// Rev 1.0
// ============================================================
interface bytestriping_n_if
  import bs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    last_in;
  logic                    ready_in;
  logic [LANES-1:0]        lane_en;
  logic [LANES*DATA_W-1:0] lanes_out;
  logic [LANES-1:0]        valid_out;
  logic                    ready_out;
  logic [CNT_W-1:0]        stripes_out;

  modport master (
    output data_in, valid_in, last_in, lane_en, ready_out,
    input  ready_in, lanes_out, valid_out, stripes_out
  );

  modport slave (
    input  data_in, valid_in, last_in, lane_en, ready_out,
    output ready_in, lanes_out, valid_out, stripes_out
  );

endinterface
`default_nettype wire

// File: rtl/bytestriping_n_lane_sel.sv
`default_nettype none
// ============================================================
// bs_lane_sel : next-enabled-lane / first-lane finder
// Rev 1.0
// ============================================================
module bs_lane_sel
  import bs_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  localparam int LW    = clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  input  logic [LW-1:0]    ptr,
  output logic [LW-1:0]    next_ptr,
  output logic             is_last_lane,
  output logic [LW-1:0]    first_lane
);

  always_comb begin
    first_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) first_lane = LW'(i);
    end
  end

  // Scanning downward leaves the lowest enabled lane above ptr.
  always_comb begin
    next_ptr     = ptr;
    is_last_lane = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (LW'(i) > ptr)) begin
        next_ptr     = LW'(i);
        is_last_lane = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bytestriping_n.sv
`default_nettype none
// ============================================================
// bytestriping_n : round-robin word striper over LANES lanes
// Rev 1.0
// ============================================================
module bytestriping_n
  import bs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk_f,
  input  logic             reset,
  bytestriping_n_if.slave  bus
);

  localparam int LW = clog2(LANES);

  fill_state_t             r_state;
  fill_state_t             w_state_nxt;
  logic [LANES-1:0]        r_mask;
  logic [LANES-1:0]        r_written;
  logic [LW-1:0]           r_ptr;
  logic [DATA_W-1:0]       r_fill [LANES];
  logic [LANES*DATA_W-1:0] r_lanes;
  logic [LANES-1:0]        r_valid_out;
  logic [CNT_W-1:0]        r_stripes;

  logic [LANES-1:0]        w_mask;
  logic [LANES-1:0]        w_ptr_bit;
  logic [LANES-1:0]        w_vout_nxt;
  logic [LW-1:0]           w_ptr;
  logic [LW-1:0]           w_next_ptr;
  logic [LW-1:0]           w_first_lane;
  logic                    w_is_last;
  logic [LANES*DATA_W-1:0] w_lanes_nxt;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_xfer;

  // In IDLE the live lane_en is used so a new stripe sees the current mask.
  assign w_mask = (r_state == IDLE)
                ? ((bus.lane_en == '0) ? LANES'(1) : bus.lane_en)
                : r_mask;
  assign w_ptr     = (r_state == IDLE) ? w_first_lane : r_ptr;
  assign w_ptr_bit = LANES'(1) << w_ptr;

  bs_lane_sel #(.LANES(LANES)) u_lane_sel (
    .mask         (w_mask),
    .ptr          (w_ptr),
    .next_ptr     (w_next_ptr),
    .is_last_lane (w_is_last),
    .first_lane   (w_first_lane)
  );

  assign w_out_valid  = |r_valid_out;
  assign bus.ready_in = !w_out_valid || bus.ready_out;
  assign w_accept     = bus.valid_in && bus.ready_in;
  assign w_done       = w_accept && (w_is_last || bus.last_in);
  assign w_xfer       = w_out_valid && bus.ready_out;

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_done ? IDLE : FILL;
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_mask    <= '0;
      r_ptr     <= '0;
      r_written <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_written <= '0;
      end else begin
        r_written <= r_written | w_ptr_bit;
        r_ptr     <= w_next_ptr;
        r_mask    <= w_mask;
      end
    end
  end

  // Fill data needs no reset: r_written gates which entries are ever used.
  always_ff @(posedge clk_f) begin
    if (w_accept) r_fill[w_ptr] <= bus.data_in;
  end

  always_comb begin
    w_vout_nxt  = r_written | w_ptr_bit;
    w_lanes_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_ptr == LW'(i))  w_lanes_nxt[i*DATA_W +: DATA_W] = bus.data_in;
      else if (r_written[i]) w_lanes_nxt[i*DATA_W +: DATA_W] = r_fill[i];
    end
  end

  // A completing word overrides a same-cycle transfer so there is no bubble.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_lanes     <= '0;
      r_valid_out <= '0;
    end else if (w_done) begin
      r_lanes     <= w_lanes_nxt;
      r_valid_out <= w_vout_nxt;
    end else if (w_xfer) begin
      r_lanes     <= '0;
      r_valid_out <= '0;
    end
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset)      r_stripes <= '0;
    else if (w_xfer) r_stripes <= r_stripes + CNT_W'(1);
  end

  assign bus.lanes_out   = r_lanes;
  assign bus.valid_out   = r_valid_out;
  assign bus.stripes_out = r_stripes;

endmodule
`default_nettype wire

// File: tb/tb_bytestriping_n.sv
`default_nettype none
// ============================================================
// tb_bytestriping_n : directed self-checking bench, 4 x 32-bit lanes
// Rev 1.0
// ============================================================
module tb_bytestriping_n;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bytestriping_n_if #(.DATA_W(32), .LANES(4), .CNT_W(16)) bus ();

  bytestriping_n #(.DATA_W(32), .LANES(4), .CNT_W(16)) dut (
    .clk_f (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    bus.last_in  = l;
    n = 0;
    @(negedge clk);
    while (!bus.ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.ready_in !== 1'b1) begin
      fails++;
      $display("FAIL send_wait ready_in=%b required 1 (word %h)", bus.ready_in, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_in = '0; bus.valid_in = 1'b0; bus.last_in = 1'b0;
    bus.lane_en = 4'hF; bus.ready_out = 1'b1;
    #2;
    tests++; if (bus.valid_out !== 4'h0) begin fails++; $display("FAIL rst_valid got=%h exp=0", bus.valid_out); end
    tests++; if (bus.lanes_out !== 128'h0) begin fails++; $display("FAIL rst_lanes got=%h exp=0", bus.lanes_out); end
    tests++; if (bus.stripes_out !== 16'h0) begin fails++; $display("FAIL rst_stripes got=%h exp=0", bus.stripes_out); end
    tests++; if (bus.ready_in !== 1'b1) begin fails++; $display("FAIL rst_ready_in got=%b exp=1", bus.ready_in); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_stripes();
    bus.lane_en = 4'hF; bus.ready_out = 1'b1;
    for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 1'b0);
    tests++; if (bus.valid_out !== 4'hF) begin fails++; $display("FAIL full1_valid got=%h exp=f", bus.valid_out); end
    tests++; if (bus.lanes_out !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin fails++; $display("FAIL full1_lanes got=%h", bus.lanes_out); end
    send(32'hA4, 1'b0);
    tests++; if (bus.valid_out !== 4'h0) begin fails++; $display("FAIL full1_pulse got=%h exp=0", bus.valid_out); end
    tests++; if (bus.stripes_out !== 16'd1) begin fails++; $display("FAIL full1_count got=%0d exp=1", bus.stripes_out); end
    for (int i = 5; i < 8; i++) send(32'hA0 + 32'(i), 1'b0);
    tests++; if (bus.valid_out !== 4'hF) begin fails++; $display("FAIL full2_valid got=%h exp=f", bus.valid_out); end
    tests++; if (bus.lanes_out !== {32'hA7, 32'hA6, 32'hA5, 32'hA4}) begin fails++; $display("FAIL full2_lanes got=%h", bus.lanes_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd2) begin fails++; $display("FAIL full_count got=%0d exp=2", bus.stripes_out); end
  endtask

  task automatic test_sparse();
    bus.lane_en = 4'b0101;
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    tests++; if (bus.valid_out !== 4'b0101) begin fails++; $display("FAIL sparse_valid got=%b exp=0101", bus.valid_out); end
    tests++; if (bus.lanes_out !== {32'h0, 32'h22, 32'h0, 32'h11}) begin fails++; $display("FAIL sparse_lanes got=%h", bus.lanes_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd3) begin fails++; $display("FAIL sparse_count got=%0d exp=3", bus.stripes_out); end
  endtask

  task automatic test_early_term();
    bus.lane_en = 4'hF;
    send(32'h1, 1'b0);
    bus.valid_in = 1'b0; bus.last_in = 1'b1;
    @(posedge clk); #1;
    tests++; if (bus.valid_out !== 4'h0) begin fails++; $display("FAIL early_lastnovalid got=%b exp=0000", bus.valid_out); end
    send(32'h2, 1'b0);
    send(32'h3, 1'b1);
    tests++; if (bus.valid_out !== 4'b0111) begin fails++; $display("FAIL early_valid got=%b exp=0111", bus.valid_out); end
    tests++; if (bus.lanes_out !== {32'h0, 32'h3, 32'h2, 32'h1}) begin fails++; $display("FAIL early_lanes got=%h", bus.lanes_out); end
    send(32'h4, 1'b1);
    tests++; if (bus.valid_out !== 4'b0001) begin fails++; $display("FAIL early_next_valid got=%b exp=0001", bus.valid_out); end
    tests++; if (bus.lanes_out !== {32'h0, 32'h0, 32'h0, 32'h4}) begin fails++; $display("FAIL early_next_lanes got=%h", bus.lanes_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd5) begin fails++; $display("FAIL early_count got=%0d exp=5", bus.stripes_out); end
  endtask

  task automatic test_backpressure();
    bus.lane_en = 4'hF; bus.ready_out = 1'b1;
    for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i), 1'b0);
    bus.ready_out = 1'b0;
    bus.data_in = 32'hB4; bus.valid_in = 1'b1; bus.last_in = 1'b0;
    #1;
    tests++; if (bus.ready_in !== 1'b0) begin fails++; $display("FAIL bp_ready_in got=%b exp=0", bus.ready_in); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.valid_out !== 4'hF || bus.lanes_out !== {32'hB3, 32'hB2, 32'hB1, 32'hB0} || bus.ready_in !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d valid=%h lanes=%h ready_in=%b exp f/b3b2b1b0/0", c, bus.valid_out, bus.lanes_out, bus.ready_in);
      end
    end
    bus.ready_out = 1'b1;
    send(32'hB4, 1'b0);
    tests++; if (bus.valid_out !== 4'h0) begin fails++; $display("FAIL bp_release_valid got=%h exp=0", bus.valid_out); end
    tests++; if (bus.stripes_out !== 16'd6) begin fails++; $display("FAIL bp_release_count got=%0d exp=6", bus.stripes_out); end
    tests++; if (bus.ready_in !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", bus.ready_in); end
    for (int i = 5; i < 8; i++) send(32'hB0 + 32'(i), 1'b0);
    tests++; if (bus.lanes_out !== {32'hB7, 32'hB6, 32'hB5, 32'hB4} || bus.valid_out !== 4'hF) begin fails++; $display("FAIL bp_s2 lanes=%h valid=%h", bus.lanes_out, bus.valid_out); end
    for (int i = 8; i < 12; i++) send(32'hB0 + 32'(i), 1'b0);
    tests++; if (bus.lanes_out !== {32'hBB, 32'hBA, 32'hB9, 32'hB8} || bus.valid_out !== 4'hF) begin fails++; $display("FAIL bp_s3 lanes=%h valid=%h", bus.lanes_out, bus.valid_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd8) begin fails++; $display("FAIL bp_count got=%0d exp=8", bus.stripes_out); end
  endtask

  task automatic test_reset_mid();
    bus.lane_en = 4'hF;
    send(32'hC0, 1'b0);
    send(32'hC1, 1'b0);
    bus.valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.stripes_out !== 16'h0) begin fails++; $display("FAIL rmid_stripes got=%0d exp=0", bus.stripes_out); end
    tests++; if (bus.valid_out !== 4'h0 || bus.lanes_out !== 128'h0) begin fails++; $display("FAIL rmid_out valid=%h lanes=%h exp 0", bus.valid_out, bus.lanes_out); end
    tests++; if (bus.ready_in !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", bus.ready_in); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(32'hE0 + 32'(i), 1'b0);
    tests++; if (bus.valid_out !== 4'hF || bus.lanes_out !== {32'hE3, 32'hE2, 32'hE1, 32'hE0}) begin fails++; $display("FAIL rmid_fresh valid=%h lanes=%h", bus.valid_out, bus.lanes_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd1) begin fails++; $display("FAIL rmid_count got=%0d exp=1", bus.stripes_out); end
  endtask

  task automatic test_mask_edges();
    bus.lane_en = 4'hF;
    send(32'h51, 1'b0);
    bus.lane_en = 4'h3;
    send(32'h52, 1'b0);
    send(32'h53, 1'b0);
    send(32'h54, 1'b0);
    tests++; if (bus.valid_out !== 4'hF || bus.lanes_out !== {32'h54, 32'h53, 32'h52, 32'h51}) begin fails++; $display("FAIL mask_midchange valid=%h lanes=%h", bus.valid_out, bus.lanes_out); end
    send(32'h61, 1'b0);
    send(32'h62, 1'b0);
    tests++; if (bus.valid_out !== 4'b0011 || bus.lanes_out !== {32'h0, 32'h0, 32'h62, 32'h61}) begin fails++; $display("FAIL mask_new3 valid=%b lanes=%h", bus.valid_out, bus.lanes_out); end
    bus.lane_en = 4'h0;
    send(32'h71, 1'b0);
    tests++; if (bus.valid_out !== 4'b0001 || bus.lanes_out !== {32'h0, 32'h0, 32'h0, 32'h71}) begin fails++; $display("FAIL mask_zero1 valid=%b lanes=%h", bus.valid_out, bus.lanes_out); end
    send(32'h72, 1'b0);
    tests++; if (bus.valid_out !== 4'b0001 || bus.lanes_out !== {32'h0, 32'h0, 32'h0, 32'h72}) begin fails++; $display("FAIL mask_zero2 valid=%b lanes=%h", bus.valid_out, bus.lanes_out); end
    idle();
    tests++; if (bus.stripes_out !== 16'd5) begin fails++; $display("FAIL mask_count got=%0d exp=5", bus.stripes_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_stripes();
    test_sparse();
    test_early_term();
    test_backpressure();
    test_reset_mid();
    test_mask_edges();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
